// File: rtl/ram_port_arbiter.sv
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Two-master round-robin arbiter for the shared single-port RAM.
//             Master 0 is the CPU and master 1 a loader/debug requester.
//             Bursts are bounded to MAX_BURST accesses while the other side
//             waits. One-cycle read returns are tagged per master.
//  Options  : define ARB_STATS_EN to add per-master 16-bit access counters
//             (m0_grantCount / m1_grantCount).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
    parameter int SIZE      = 10,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_wrEn,
    input  logic [SIZE-1:0] m0_addr,
    input  logic [31:0]     m0_data,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    input  logic            m1_req,
    input  logic            m1_wrEn,
    input  logic [SIZE-1:0] m1_addr,
    input  logic [31:0]     m1_data,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    input  logic [31:0]     data_fromRAM,
    output logic            wrEn,
    output logic [SIZE-1:0] addr_toRAM,
    output logic [31:0]     data_toRAM,
    output logic [31:0]     rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]     m0_grantCount,
    output logic [15:0]     m1_grantCount
`endif
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_OWN0 = 2'd1;
    localparam logic [1:0]  c_OWN1 = 2'd2;

    localparam logic [CW:0]   c_BURST_MAX = (CW+1)'(MAX_BURST);
    localparam logic [CW-1:0] c_BURST_SAT = CW'(MAX_BURST - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_burst;
    logic          r_last;      // last-served master
    logic          r_m0_rvalid;
    logic          r_m1_rvalid;

    logic [1:0]    w_next_state;
    logic [CW-1:0] w_next_burst;
    logic          w_next_last;
    logic          w_acc0;
    logic          w_acc1;
    logic [CW:0]   w_burst_inc;
    logic [CW-1:0] w_burst_stay;

    // Reset masks everything visible so nothing leaks during the reset cycle
    assign m0_gnt    = (r_state == c_OWN0) && !rst;
    assign m1_gnt    = (r_state == c_OWN1) && !rst;
    assign w_acc0    = m0_gnt && m0_req;
    assign w_acc1    = m1_gnt && m1_req;
    assign m0_rvalid = r_m0_rvalid && !rst;
    assign m1_rvalid = r_m1_rvalid && !rst;
    assign rdata     = data_fromRAM;

    assign w_burst_inc  = {1'b0, r_burst} + (CW+1)'(1);
    // Saturate when the other master is idle so a late requester waits at most one access
    assign w_burst_stay = (r_burst == c_BURST_SAT) ? c_BURST_SAT : (r_burst + CW'(1));

    // Drive RAM controls from the master performing an access, zero otherwise
    always_comb begin
        wrEn       = 1'b0;
        addr_toRAM = '0;
        data_toRAM = '0;
        if (w_acc0) begin
            wrEn       = m0_wrEn;
            addr_toRAM = m0_addr;
            data_toRAM = m0_data;
        end else if (w_acc1) begin
            wrEn       = m1_wrEn;
            addr_toRAM = m1_addr;
            data_toRAM = m1_data;
        end
    end

    // Round-robin next-state, burst counter and last-served logic
    always_comb begin
        w_next_state = r_state;
        w_next_burst = r_burst;
        w_next_last  = r_last;
        case (r_state)
            c_IDLE: begin
                w_next_burst = '0;
                if (m0_req && m1_req) begin
                    w_next_state = r_last ? c_OWN0 : c_OWN1;
                end else if (m0_req) begin
                    w_next_state = c_OWN0;
                end else if (m1_req) begin
                    w_next_state = c_OWN1;
                end
            end
            c_OWN0: begin
                if (!m0_req) begin
                    w_next_state = m1_req ? c_OWN1 : c_IDLE;
                    w_next_burst = '0;
                    w_next_last  = 1'b0;
                end else if ((w_burst_inc == c_BURST_MAX) && m1_req) begin
                    w_next_state = c_OWN1;
                    w_next_burst = '0;
                    w_next_last  = 1'b0;
                end else begin
                    w_next_burst = w_burst_stay;
                end
            end
            c_OWN1: begin
                if (!m1_req) begin
                    w_next_state = m0_req ? c_OWN0 : c_IDLE;
                    w_next_burst = '0;
                    w_next_last  = 1'b1;
                end else if ((w_burst_inc == c_BURST_MAX) && m0_req) begin
                    w_next_state = c_OWN0;
                    w_next_burst = '0;
                    w_next_last  = 1'b1;
                end else begin
                    w_next_burst = w_burst_stay;
                end
            end
            default: begin
                w_next_state = c_IDLE;
                w_next_burst = '0;
            end
        endcase
    end

    // State registers and one-cycle read-return tags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_burst     <= '0;
            r_last      <= 1'b1;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_burst     <= w_next_burst;
            r_last      <= w_next_last;
            r_m0_rvalid <= w_acc0 && !m0_wrEn;
            r_m1_rvalid <= w_acc1 && !m1_wrEn;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_m0_cnt;
    logic [15:0] r_m1_cnt;

    // Per-master access counters, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_cnt <= '0;
            r_m1_cnt <= '0;
        end else begin
            if (w_acc0) r_m0_cnt <= r_m0_cnt + 16'd1;
            if (w_acc1) r_m1_cnt <= r_m1_cnt + 16'd1;
        end
    end

    assign m0_grantCount = r_m0_cnt;
    assign m1_grantCount = r_m1_cnt;
`endif

endmodule

`default_nettype wire
